// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer around a single FULLADDER cell, LSB first.
// Optional overflow output is enabled with `define SERADD_OVF_EN.

module FULLADDER (
  input  logic a,
  input  logic b,
  input  logic cy_in,
  output logic sum,
  output logic cy_out
);

  assign sum    = a ^ b ^ cy_in;
  assign cy_out = (a & b) | (a & cy_in) | (b & cy_in);

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cy_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERADD_OVF_EN
  output logic             ovf,
`endif
  output logic             cy_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CNT_W-1:0] cnt;
  logic             cy;
  logic             fa_s, fa_c;
  logic             last_bit;

  FULLADDER u_fa (
    .a      (a_sr[0]),
    .b      (b_sr[0]),
    .cy_in  (cy),
    .sum    (fa_s),
    .cy_out (fa_c)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // busy/done are registered from the state, so each lags the state by one edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state == RUN);
      done <= (state == FIN);
    end
  end

`ifdef SERADD_OVF_EN
  logic cy_msb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cy_msb <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (state == RUN && last_bit) cy_msb <= cy;
      if (state == FIN)             ovf    <= cy_msb ^ cy;
    end
  end
`endif

  // Operands shift out LSB first; result bits enter SUM at the MSB end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      cy     <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cy_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr <= a;
            b_sr <= sub ? ~b : b;
            cy   <= sub ? 1'b1 : cy_in;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          sum  <= {fa_s, sum[WIDTH-1:1]};
          cy   <= fa_c;
          cnt  <= cnt + 1'b1;
        end
        FIN: cy_out <= cy;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8).
// Define SERADD_OVF_EN to also exercise the overflow output.

module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, sub, cy_in;
  logic [7:0] a, b;
  logic       busy, done, cy_out;
  logic [7:0] sum;
`ifdef SERADD_OVF_EN
  logic       ovf;
`endif

  int total = 0;
  int bad   = 0;

  serial_add_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .cy_in  (cy_in),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
`ifdef SERADD_OVF_EN
    .ovf    (ovf),
`endif
    .cy_out (cy_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Launch one operation and follow it through BUSY and the DONE pulse
  task automatic applyStimulus(input string tag, input logic [7:0] av, input logic [7:0] bv,
                               input logic subv, input logic cyv,
                               input logic [7:0] expSum, input logic expCy);
    int busyCycles;
    a = av; b = bv; sub = subv; cy_in = cyv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput({tag, "_busy_lag"}, busy, 1'b0);
    busyCycles = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (busy) busyCycles++;
      if (done) busyCycles += 100;
    end
    checkOutput({tag, "_busy_cycles"}, busyCycles, 8);
    @(posedge clk); #1;
    checkOutput({tag, "_done"}, done, 1'b1);
    checkOutput({tag, "_busy_off"}, busy, 1'b0);
    checkOutput({tag, "_sum"}, sum, expSum);
    checkOutput({tag, "_cy"}, cy_out, expCy);
    @(posedge clk); #1;
    checkOutput({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int doneCount;
    logic [7:0] sumAtDone;

    rst = 1'b1; start = 1'b0; sub = 1'b0; cy_in = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_sum", sum, 8'h00);
    checkOutput("reset_cy", cy_out, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus("add_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0);
    applyStimulus("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus("add_ff_01_ci", 8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1);
    applyStimulus("sub_10_01", 8'h10, 8'h01, 1'b1, 1'b0, 8'h0F, 1'b1);
    applyStimulus("sub_01_02", 8'h01, 8'h02, 1'b1, 1'b0, 8'hFF, 1'b0);
    applyStimulus("sub_cyin_ignored", 8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1);

    // A second START during RUN must be dropped entirely
    a = 8'h01; b = 8'h01; sub = 1'b0; cy_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a = 8'hF0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    doneCount = 0;
    sumAtDone = 8'h00;
    repeat (16) begin
      @(posedge clk); #1;
      if (done) begin
        doneCount++;
        sumAtDone = sum;
      end
    end
    checkOutput("ignore_start_done_count", doneCount, 1);
    checkOutput("ignore_start_sum", sumAtDone, 8'h02);

    // Asynchronous reset in the middle of RUN
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrun_rst_busy", busy, 1'b0);
    checkOutput("midrun_rst_done", done, 1'b0);
    checkOutput("midrun_rst_sum", sum, 8'h00);
    checkOutput("midrun_rst_cy", cy_out, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus("after_rst_22_11", 8'h22, 8'h11, 1'b0, 1'b0, 8'h33, 1'b0);

`ifdef SERADD_OVF_EN
    applyStimulus("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0);
    checkOutput("ovf_7f_01_flag", ovf, 1'b1);
    applyStimulus("ovf_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("ovf_ff_01_flag", ovf, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
